pipelined_controller: RTL

//   Parametrised pipelined decode/control stage for the 16-bit MIPS-style core.

---
 rtl/pipelined_controller.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/pipelined_controller.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_controller
// Purpose  : ID-stage decode registered into ID/EX, with a load-use stall and
//            squashing of wrong-path instructions after a taken branch.
//            Optional performance counters are enabled by CTRL_PERF_CNT_EN.
// Revision : 1.0  initial release
// ============================================================================
module pipelined_controller #(
  parameter int INSTR_W      = 16,
  parameter int OPC_W        = 4,
  parameter int REG_ADDR_W   = 3,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  instr_valid_i,
  input  logic [INSTR_W-1:0]    instruction_i,
  input  logic                  mem_busy_i,
  input  logic                  branch_taken_i,
  output logic                  id_ready_o,
  output logic                  ex_valid_o,
  output logic [2:0]            ex_alu_cmd_o,
  output logic                  ex_wr_en_o,
  output logic                  ex_br_comm_o,
  output logic                  ex_alu_src2_imm_o,
  output logic                  ex_mem_store_o,
  output logic                  ex_is_mem_o,
  output logic                  ex_wb_mem_sel_o,
  output logic [REG_ADDR_W-1:0] ex_rd_o,
  output logic [15:0]           perf_stalls_o,
  output logic [15:0]           perf_flushes_o
);

  localparam int                 c_cnt_w    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(FLUSH_CYCLES - 1);
  localparam int                 c_rd_msb   = INSTR_W - OPC_W - 1;
  localparam int                 c_rs1_msb  = c_rd_msb - REG_ADDR_W;
  localparam int                 c_rs2_msb  = c_rs1_msb - REG_ADDR_W;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  typedef struct packed {
    logic [2:0]            alu_cmd;
    logic                  wr_en;
    logic                  br_comm;
    logic                  alu_src2_imm;
    logic                  mem_store;
    logic                  is_mem;
    logic                  wb_mem_sel;
    logic [REG_ADDR_W-1:0] rd;
  } ctrl_t;

  state_t             state_q;
  logic [c_cnt_w-1:0] flush_cnt_q;
  logic               ex_valid_q;
  ctrl_t              ex_q;

  logic                  w_upper_nz;
  logic [3:0]            w_op;
  logic [REG_ADDR_W-1:0] w_rd;
  logic [REG_ADDR_W-1:0] w_rs1;
  logic [REG_ADDR_W-1:0] w_rs2;
  ctrl_t                 w_dec;
  logic                  w_reads_rs1;
  logic                  w_reads_rs2;
  logic                  w_reads_rd;
  logic                  w_ex_is_load;
  logic                  w_load_use;
  logic                  w_flush;
  logic                  w_unused_instr;

  // Opcodes wider than the 4-bit decode table decode as NOP when upper bits are set
  generate
    if (OPC_W > 4) begin : g_wide_opc
      assign w_upper_nz = |instruction_i[INSTR_W-1 -: OPC_W-4];
    end else begin : g_narrow_opc
      assign w_upper_nz = 1'b0;
    end
  endgenerate

  assign w_op           = w_upper_nz ? 4'h0 : instruction_i[INSTR_W-OPC_W +: 4];
  assign w_rd           = instruction_i[c_rd_msb  -: REG_ADDR_W];
  assign w_rs1          = instruction_i[c_rs1_msb -: REG_ADDR_W];
  assign w_rs2          = instruction_i[c_rs2_msb -: REG_ADDR_W];
  assign w_unused_instr = ^instruction_i;

  always_comb begin
    w_dec    = '0;
    w_dec.rd = w_rd;
    case (w_op)
      4'h1, 4'h9, 4'hA, 4'hB: w_dec.alu_cmd = 3'b000;
      4'h2:                   w_dec.alu_cmd = 3'b001;
      4'h3:                   w_dec.alu_cmd = 3'b010;
      4'h4:                   w_dec.alu_cmd = 3'b011;
      4'h5:                   w_dec.alu_cmd = 3'b100;
      4'h6:                   w_dec.alu_cmd = 3'b101;
      4'h7:                   w_dec.alu_cmd = 3'b110;
      default:                w_dec.alu_cmd = 3'b111;
    endcase
    w_dec.wr_en        = (w_op != 4'h0) && (w_op != 4'hB) && (w_op < 4'hC);
    w_dec.br_comm      = (w_op == 4'hC);
    w_dec.alu_src2_imm = (w_op >= 4'h9) && (w_op <= 4'hB);
    w_dec.mem_store    = (w_op == 4'hB);
    w_dec.is_mem       = (w_op == 4'hA) || (w_op == 4'hB);
    w_dec.wb_mem_sel   = (w_op == 4'hA);
  end

  // rs2 is only meaningful for instructions that use register operands at all
  assign w_reads_rs1  = (w_op != 4'h0) && (w_op <= 4'hC);
  assign w_reads_rs2  = w_reads_rs1 && (!w_dec.alu_src2_imm || (w_op == 4'hC));
  assign w_reads_rd   = (w_op == 4'hB);

  assign w_ex_is_load = ex_valid_q && ex_q.wb_mem_sel && ex_q.wr_en;
  assign w_load_use   = (state_q == ST_RUN) && w_ex_is_load && instr_valid_i &&
                        ((w_reads_rs1 && (w_rs1 == ex_q.rd)) ||
                         (w_reads_rs2 && (w_rs2 == ex_q.rd)) ||
                         (w_reads_rd  && (w_rd  == ex_q.rd)));
  assign w_flush      = ex_valid_q && ex_q.br_comm && branch_taken_i;

  assign id_ready_o   = !mem_busy_i && !w_flush && (state_q != ST_FLUSH) && !w_load_use;

  // The edge that detects the taken branch squashes the first wrong-path slot,
  // so FLUSH itself lasts FLUSH_CYCLES-1 cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= '0;
      ex_valid_q  <= 1'b0;
      ex_q        <= '0;
    end else if (!mem_busy_i) begin
      if (w_flush) begin
        ex_valid_q <= 1'b0;
        ex_q       <= '0;
        if (FLUSH_CYCLES > 1) begin
          state_q     <= ST_FLUSH;
          flush_cnt_q <= c_cnt_init;
        end else begin
          state_q     <= ST_RUN;
          flush_cnt_q <= '0;
        end
      end else if (state_q == ST_FLUSH) begin
        ex_valid_q <= 1'b0;
        ex_q       <= '0;
        if (flush_cnt_q <= c_cnt_one) begin
          state_q     <= ST_RUN;
          flush_cnt_q <= '0;
        end else begin
          flush_cnt_q <= flush_cnt_q - c_cnt_one;
        end
      end else if (w_load_use) begin
        ex_valid_q <= 1'b0;
        ex_q       <= '0;
        state_q    <= ST_STALL;
      end else begin
        state_q    <= ST_RUN;
        ex_valid_q <= instr_valid_i;
        ex_q       <= instr_valid_i ? w_dec : '0;
      end
    end
  end

  assign ex_valid_o        = ex_valid_q;
  assign ex_alu_cmd_o      = ex_q.alu_cmd;
  assign ex_wr_en_o        = ex_q.wr_en;
  assign ex_br_comm_o      = ex_q.br_comm;
  assign ex_alu_src2_imm_o = ex_q.alu_src2_imm;
  assign ex_mem_store_o    = ex_q.mem_store;
  assign ex_is_mem_o       = ex_q.is_mem;
  assign ex_wb_mem_sel_o   = ex_q.wb_mem_sel;
  assign ex_rd_o           = ex_q.rd;

`ifdef CTRL_PERF_CNT_EN
  logic [15:0] perf_stalls_q;
  logic [15:0] perf_flushes_q;
  logic        w_stall_evt;
  logic        w_flush_evt;

  assign w_flush_evt = !mem_busy_i && w_flush;
  assign w_stall_evt = !mem_busy_i && !w_flush && w_load_use;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stalls_q  <= '0;
      perf_flushes_q <= '0;
    end else begin
      if (w_stall_evt && (perf_stalls_q != 16'hFFFF)) begin
        perf_stalls_q <= perf_stalls_q + 16'd1;
      end
      if (w_flush_evt && (perf_flushes_q != 16'hFFFF)) begin
        perf_flushes_q <= perf_flushes_q + 16'd1;
      end
    end
  end

  assign perf_stalls_o  = perf_stalls_q;
  assign perf_flushes_o = perf_flushes_q;
`else
  assign perf_stalls_o  = 16'h0000;
  assign perf_flushes_o = 16'h0000;
`endif

endmodule
`default_nettype wire
